// File: rtl/activation_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : activation_stream_unit
// Brief    : Per-vector activation stage (bypass / sigmoid / tanh / ReLU)
//            between the array EAST output and NORTH input buses. Sigmoid and
//            tanh are delegated to external units via start/done with a
//            timeout; results queue in an output FIFO tagged with the mode.
//            Optional macro ACT_LEAKY_RELU_EN turns mode 3 into leaky ReLU.
// Revision : 1.0 - initial release
// ============================================================================
module activation_stream_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 16,
    parameter int LEAK_SHIFT  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WORD_LENGTH-1:0] in_data,
    input  logic [1:0]                   in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WORD_LENGTH-1:0] out_data,
    output logic [1:0]                   out_mode,
    output logic [LANES*WORD_LENGTH-1:0] act_operand,
    output logic                         sig_start,
    input  logic                         sig_done,
    input  logic [LANES*WORD_LENGTH-1:0] sig_result,
    output logic                         tanh_start,
    input  logic                         tanh_done,
    input  logic [LANES*WORD_LENGTH-1:0] tanh_result,
    output logic                         err_timeout,
    output logic                         busy
);

    localparam int VW = LANES * WORD_LENGTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_push = 2'd2;

    localparam logic [1:0] c_mode_sig  = 2'd1;
    localparam logic [1:0] c_mode_tanh = 2'd2;
    localparam logic [1:0] c_mode_relu = 2'd3;

    localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

    // Shift amounts outside the lane width give no meaningful leaky slope.
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= WORD_LENGTH) begin : g_leak_shift_out_of_range
    end

    logic [1:0]    state_q,      state_d;
    logic [1:0]    mode_q,       mode_d;
    logic [VW-1:0] result_q,     result_d;
    logic [VW-1:0] operand_q,    operand_d;
    logic          sig_start_q,  sig_start_d;
    logic          tanh_start_q, tanh_start_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic          err_q,        err_d;
    logic          wr_en_q,      wr_en_d;
    logic [VW+1:0] wr_word_q,    wr_word_d;
    logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0] count_q,      count_d;
    logic [VW+1:0] mem_q [FIFO_DEPTH];

    logic [VW-1:0] w_relu;
    logic [VW+1:0] w_head;
    logic          w_accept;
    logic          w_pop;

    assign w_accept    = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign act_operand = operand_q;
    assign sig_start   = sig_start_q;
    assign tanh_start  = tanh_start_q;
    assign err_timeout = err_q;

    // Lane-wise rectifier on the incoming vector (negative lanes clamp or leak).
    always_comb begin
        w_relu = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_data[i*WORD_LENGTH + WORD_LENGTH - 1]) begin
`ifdef ACT_LEAKY_RELU_EN
                w_relu[i*WORD_LENGTH +: WORD_LENGTH] =
                    WORD_LENGTH'($signed(in_data[i*WORD_LENGTH +: WORD_LENGTH]) >>> LEAK_SHIFT);
`else
                w_relu[i*WORD_LENGTH +: WORD_LENGTH] = '0;
`endif
            end else begin
                w_relu[i*WORD_LENGTH +: WORD_LENGTH] = in_data[i*WORD_LENGTH +: WORD_LENGTH];
            end
        end
    end

    // Next-state and datapath for the single in-flight vector.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        result_d     = result_q;
        operand_d    = operand_q;
        sig_start_d  = 1'b0;
        tanh_start_d = 1'b0;
        timer_d      = timer_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_word_d    = wr_word_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    mode_d  = in_mode;
                    timer_d = '0;
                    case (in_mode)
                        c_mode_sig: begin
                            operand_d   = in_data;
                            sig_start_d = 1'b1;
                            state_d     = c_st_wait;
                        end
                        c_mode_tanh: begin
                            operand_d    = in_data;
                            tanh_start_d = 1'b1;
                            state_d      = c_st_wait;
                        end
                        c_mode_relu: begin
                            result_d = w_relu;
                            state_d  = c_st_push;
                        end
                        default: begin
                            result_d = in_data;
                            state_d  = c_st_push;
                        end
                    endcase
                end
            end
            c_st_wait: begin
                // Only the selected unit's done counts; it beats a same-edge timeout.
                if (mode_q == c_mode_sig && sig_done) begin
                    result_d = sig_result;
                    state_d  = c_st_push;
                end else if (mode_q == c_mode_tanh && tanh_done) begin
                    result_d = tanh_result;
                    state_d  = c_st_push;
                end else if (timer_q == c_tmo_last) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = c_st_push;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            c_st_push: begin
                // The FIFO write is registered, landing one edge after PUSH.
                wr_en_d   = 1'b1;
                wr_word_d = {mode_q, result_q};
                state_d   = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_q) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en_q, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Status and FIFO head outputs; a pending write already holds its slot.
    always_comb begin
        w_head    = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_data  = out_valid ? w_head[VW-1:0]  : '0;
        out_mode  = out_valid ? w_head[VW+1:VW] : '0;
        in_ready  = (state_q == c_st_idle) && ((count_q + CW'(wr_en_q)) < c_depth) && !reset;
        busy      = (state_q != c_st_idle);
    end

    // State register; reset drops any in-flight vector and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_st_idle;
            mode_q       <= '0;
            result_q     <= '0;
            operand_q    <= '0;
            sig_start_q  <= 1'b0;
            tanh_start_q <= 1'b0;
            timer_q      <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_word_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            result_q     <= result_d;
            operand_q    <= operand_d;
            sig_start_q  <= sig_start_d;
            tanh_start_q <= tanh_start_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_word_q    <= wr_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_q) begin
            mem_q[wr_ptr_q] <= wr_word_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_activation_stream_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_stream_unit
// Brief    : Scoreboard bench for activation_stream_unit (default parameters).
//            Honours ACT_LEAKY_RELU_EN when computing mode-3 expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation_stream_unit;

    localparam int VW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [1:0]    out_mode;
    logic [VW-1:0] act_operand;
    logic          sig_start;
    logic          sig_done;
    logic [VW-1:0] sig_result;
    logic          tanh_start;
    logic          tanh_done;
    logic [VW-1:0] tanh_result;
    logic          err_timeout;
    logic          busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [VW+1:0] sb_q [$];

    always #5 clk = ~clk;

    activation_stream_unit #(
        .WORD_LENGTH (32),
        .LANES       (4),
        .FIFO_DEPTH  (4),
        .TIMEOUT     (16),
        .LEAK_SHIFT  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mode    (out_mode),
        .act_operand (act_operand),
        .sig_start   (sig_start),
        .sig_done    (sig_done),
        .sig_result  (sig_result),
        .tanh_start  (tanh_start),
        .tanh_done   (tanh_done),
        .tanh_result (tanh_result),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [VW+1:0] obs, input logic [VW+1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one vector and record what must eventually come out.
    task automatic send(input logic [1:0] m, input logic [VW-1:0] d, input logic [VW-1:0] exp_d);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("send_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        sb_q.push_back({m, exp_d});
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_mode  = 2'd0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((out_valid || busy || sb_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check_eq("drain_empty", sb_q.size(), 0);
    endtask

    // Scoreboard: compare the head whenever it will be popped at the next edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_output", out_valid, 0);
            end else begin
                logic [VW+1:0] e;
                e = sb_q.pop_front();
                check_eq("sb_out_data", out_data, e[VW-1:0]);
                check_eq("sb_out_mode", out_mode, e[VW+1:VW]);
            end
        end
    end

    initial begin
        logic [VW-1:0] relu2_exp;
        logic [VW-1:0] sig_vec;
        in_valid    = 1'b0;
        in_data     = '0;
        in_mode     = 2'd0;
        out_ready   = 1'b0;
        sig_done    = 1'b0;
        sig_result  = '0;
        tanh_done   = 1'b0;
        tanh_result = '0;
        reset       = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_mode", out_mode, 0);
        check_eq("rst_act_operand", act_operand, 0);
        check_eq("rst_sig_start", sig_start, 0);
        check_eq("rst_tanh_start", tanh_start, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        check_eq("idle_in_ready", in_ready, 1);

        // ReLU and its two-edge latency
        send(2'd3, vec(32'd5, 32'hFFFF_FFFD, 32'd0, 32'h7FFF_FFFF),
                   vec(32'd5, 32'd0,         32'd0, 32'h7FFF_FFFF));
        check_eq("relu_lat_k0", out_valid, 0);
        tick();
        check_eq("relu_lat_k1", out_valid, 0);
        tick();
        check_eq("relu_lat_k2", out_valid, 1);
        check_eq("relu_busy_done", busy, 0);
`ifdef ACT_LEAKY_RELU_EN
        relu2_exp = vec(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hF000_0000);
`else
        relu2_exp = vec(32'd0, 32'd0, 32'd1, 32'd0);
`endif
        send(2'd3, vec(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000), relu2_exp);
        drain();

        // Sigmoid offload, stray tanh_done ignored
        sig_vec = vec(32'd11, 32'hFFFF_FF00, 32'd33, 32'h1234_5678);
        send(2'd1, sig_vec, {4{32'hAAAA_AAAA}});
        check_eq("sig_start_pulse", sig_start, 1);
        check_eq("sig_no_tanh_start", tanh_start, 0);
        check_eq("sig_operand", act_operand, sig_vec);
        tick();
        check_eq("sig_start_width", sig_start, 0);
        tanh_done   = 1'b1;
        tanh_result = {4{32'h5555_5555}};
        tick();
        tanh_done   = 1'b0;
        check_eq("sig_tanh_ignored_busy", busy, 1);
        sig_done   = 1'b1;
        sig_result = {4{32'hAAAA_AAAA}};
        tick();
        sig_done   = 1'b0;
        sig_result = '0;
        check_eq("sig_lat_d0", out_valid, 0);
        tick();
        check_eq("sig_lat_d1", out_valid, 0);
        tick();
        check_eq("sig_lat_d2", out_valid, 1);
        check_eq("sig_err_clear", err_timeout, 0);
        check_eq("sig_operand_held", act_operand, sig_vec);
        drain();

        // tanh done on the timeout edge wins, no error
        send(2'd2, vec(32'd1, 32'd2, 32'd3, 32'd4), vec(32'h0F0F_0F0F, 32'd7, 32'd8, 32'd9));
        check_eq("tanh_start_pulse", tanh_start, 1);
        repeat (15) tick();
        check_eq("tanh_edge_busy", busy, 1);
        tanh_done   = 1'b1;
        tanh_result = vec(32'h0F0F_0F0F, 32'd7, 32'd8, 32'd9);
        tick();
        tanh_done   = 1'b0;
        check_eq("tanh_edge_no_err", err_timeout, 0);
        drain();

        // Timeout after 16 WAIT edges
        send(2'd2, vec(32'd100, 32'd200, 32'd300, 32'd400), '0);
        repeat (15) tick();
        check_eq("tmo_err_before", err_timeout, 0);
        check_eq("tmo_busy_before", busy, 1);
        tick();
        check_eq("tmo_err_set", err_timeout, 1);
        drain();

        // FIFO full and wrap-around
        for (int i = 1; i <= 4; i++) begin
            send(2'd0, {4{32'(i)}}, {4{32'(i)}});
        end
        tick();
        tick();
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("after_pop_in_ready", in_ready, 1);
        send(2'd0, {4{32'd5}}, {4{32'd5}});
        drain();
        check_eq("err_sticky", err_timeout, 1);

        // Simultaneous write and pop with two entries queued
        send(2'd0, {4{32'hA1}}, {4{32'hA1}});
        send(2'd0, {4{32'hB2}}, {4{32'hB2}});
        tick();
        tick();
        send(2'd0, {4{32'hC3}}, {4{32'hC3}});
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("simul_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check_eq("simul_after_one", out_valid, 1);
        tick();
        out_ready = 1'b0;
        check_eq("simul_after_two", out_valid, 0);
        check_eq("simul_sb_empty", sb_q.size(), 0);

        // Reset during sigmoid WAIT with two entries queued
        send(2'd0, {4{32'hD1}}, {4{32'hD1}});
        send(2'd0, {4{32'hD2}}, {4{32'hD2}});
        send(2'd1, {4{32'hE5}}, {4{32'hE5}});
        check_eq("prerst_out_valid", out_valid, 1);
        check_eq("prerst_busy", busy, 1);
        reset = 1'b1;
        sb_q.delete();
        #1;
        check_eq("midrst_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        check_eq("postrst_out_valid", out_valid, 0);
        check_eq("postrst_busy", busy, 0);
        check_eq("postrst_err", err_timeout, 0);
        check_eq("postrst_sig_start", sig_start, 0);
        check_eq("postrst_operand", act_operand, 0);
        check_eq("postrst_out_data", out_data, 0);
        sig_done   = 1'b1;
        sig_result = {4{32'hAAAA_AAAA}};
        tick();
        sig_done   = 1'b0;
        repeat (4) tick();
        check_eq("late_done_no_out", out_valid, 0);
        check_eq("late_done_idle", busy, 0);

        // Normal operation resumes
        send(2'd0, vec(32'd9, 32'd8, 32'd7, 32'd6), vec(32'd9, 32'd8, 32'd7, 32'd6));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed stall expected finish");
        $fatal(1, "bench stalled");
    end

endmodule
`default_nettype wire
